if_fetch_queue: RTL and testbench

Instruction-fetch front end that drives the address side of the instruction memory and delivers instructions to the decode stage of the R-type pipeline.
- Owns the PC register and presents `fetch_pc` to the combinational IM each cycle.
- Captures `{pc, instr}` pairs into a DEPTH-entry FIFO.
- Hands them downstream with a valid/ready handshake.
- Accepts redirects that flush the queue.

---
 rtl/if_fetch_queue.sv | 158 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, queues {pc, instr} pairs from the IM and
// hands them to decode with valid/ready. Optional halt-opcode stop under IF_HALT_EN.
module if_fetch_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] fetch_pc,
    input  logic [31:0] im_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic [31:0] fetch_count,
    output logic        halted
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned XLEN  = 32;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [XLEN-1:0]  instr_mem [DEPTH];

    logic [XLEN-1:0]  pc_q, pc_n;
    logic [XLEN-1:0]  fetch_count_q, fetch_count_n;
    logic [PTR_W-1:0] head_q, head_n;
    logic [PTR_W-1:0] tail_q, tail_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic             valid_q, valid_n;
    logic [XLEN-1:0]  out_pc_q, out_pc_n;
    logic [XLEN-1:0]  out_instr_q, out_instr_n;

    logic             pop;
    logic             space;
    logic             push;
    logic             halt_stop;

`ifdef IF_HALT_EN
    logic             halted_q, halted_n;
    assign halt_stop = halted_q;
    assign halted    = halted_q;
`else
    assign halt_stop = 1'b0;
    assign halted    = 1'b0;
`endif

    assign pop   = valid_q & out_ready;
    assign space = (count_q < CNT_W'(DEPTH)) | pop;
    assign push  = space & ~halt_stop & ~redirect_valid;

    // Next-state for pointers, PC, counters and the registered head view
    always_comb begin
        pc_n          = pc_q;
        fetch_count_n = fetch_count_q;
        head_n        = head_q;
        tail_n        = tail_q;
        count_n       = count_q;
        valid_n       = 1'b0;
        out_pc_n      = '0;
        out_instr_n   = '0;
`ifdef IF_HALT_EN
        halted_n      = halted_q;
`endif

        if (redirect_valid) begin
            pc_n    = redirect_addr & ~XLEN'(3);
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
`ifdef IF_HALT_EN
            halted_n = 1'b0;
`endif
        end else begin
            if (push) begin
                tail_n        = tail_q + PTR_W'(1);
                pc_n          = pc_q + XLEN'(4);
                fetch_count_n = fetch_count_q + XLEN'(1);
`ifdef IF_HALT_EN
                if (im_instr[31:26] == HALT_OPCODE) begin
                    halted_n = 1'b1;
                end
`endif
            end
            if (pop) begin
                head_n = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_n = count_q + CNT_W'(1);
                2'b01:   count_n = count_q - CNT_W'(1);
                default: count_n = count_q;
            endcase
        end

        // Head view after the edge; a push landing at the new head bypasses the array
        if (count_n != '0) begin
            valid_n = 1'b1;
            if (push && (head_n == tail_q)) begin
                out_pc_n    = pc_q;
                out_instr_n = im_instr;
            end else begin
                out_pc_n    = pc_mem[head_n];
                out_instr_n = instr_mem[head_n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= START_ADDR;
            fetch_count_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            valid_q       <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
        end else begin
            pc_q          <= pc_n;
            fetch_count_q <= fetch_count_n;
            head_q        <= head_n;
            tail_q        <= tail_n;
            count_q       <= count_n;
            valid_q       <= valid_n;
            out_pc_q      <= out_pc_n;
            out_instr_q   <= out_instr_n;
        end
    end

`ifdef IF_HALT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_n;
        end
    end
`endif

    // Queue storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= pc_q;
            instr_mem[tail_q] <= im_instr;
        end
    end

    assign fetch_pc    = pc_q;
    assign fetch_count = fetch_count_q;
    assign out_valid   = valid_q;
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based scoreboard plus a PC/count model, and a second
// instance started near the top of the address space to observe PC wrap.
module tb_if_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic [31:0] im_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] fetch_count;
    logic        halted;

    logic [31:0] w_fetch_pc;
    logic [31:0] w_im_instr;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_addr;
    logic [31:0] w_fetch_count;
    logic        w_halted;

    logic        halt_mode;
    int          n_checks;
    int          n_fail;

    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_halt;

    if_fetch_queue #(.DEPTH(4), .START_ADDR(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .im_instr(im_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .fetch_count(fetch_count), .halted(halted)
    );

    if_fetch_queue #(.DEPTH(4), .START_ADDR(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_pc(w_fetch_pc), .im_instr(w_im_instr),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
        .redirect_valid(w_redirect_valid), .redirect_addr(w_redirect_addr),
        .fetch_count(w_fetch_count), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb im_instr   = (halt_mode && fetch_pc == 32'h8) ? 32'hFC00_0000 : (fetch_pc | 32'hA000_0000);
    always_comb w_im_instr = w_fetch_pc | 32'hA000_0000;

    function automatic logic [31:0] im_model(input logic [31:0] a, input logic hm);
        if (hm && a == 32'h8) return 32'hFC00_0000;
        return a | 32'hA000_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pc   = 32'h0;
        m_cnt  = 32'h0;
        m_halt = 1'b0;
    endtask

    // Called at a negedge: check outputs, drive inputs, advance model, wait next negedge
    task automatic step(input logic r, input logic rv, input logic [31:0] ra);
        logic        exp_valid;
        logic        pop;
        logic        push;
        logic [31:0] ins;
        exp_valid = (sb.size() != 0);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc", out_pc, sb[0][63:32]);
            check("out_instr", out_instr, sb[0][31:0]);
        end else begin
            check("out_pc_idle", out_pc, 32'h0);
            check("out_instr_idle", out_instr, 32'h0);
        end
        check("fetch_pc", fetch_pc, m_pc);
        check("fetch_count", fetch_count, m_cnt);
        check("halted", 32'(halted), 32'(m_halt));

        out_ready      = r;
        redirect_valid = rv;
        redirect_addr  = ra;

        pop  = exp_valid && r;
        push = ((sb.size() < 4) || pop) && !m_halt && !rv;
        if (pop) void'(sb.pop_front());
        if (rv) begin
            sb.delete();
            m_pc   = {ra[31:2], 2'b00};
            m_halt = 1'b0;
        end else if (push) begin
            ins = im_model(m_pc, halt_mode);
            sb.push_back({m_pc, ins});
`ifdef IF_HALT_EN
            if (ins[31:26] == 6'b111111) m_halt = 1'b1;
`endif
            m_pc  = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    // Wrap instance: three deliveries crossing the top of the address space
    initial begin
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        @(posedge rst_n);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wrap_valid", 32'(w_out_valid), 32'h1);
            check("wrap_pc", w_out_pc, exp_w[i]);
            check("wrap_instr", w_out_instr, exp_w[i] | 32'hA000_0000);
        end
    end

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        halt_mode        = 1'b0;
        rst_n            = 1'b0;
        out_ready        = 1'b1;
        redirect_valid   = 1'b0;
        redirect_addr    = 32'h0;
        w_out_ready      = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_addr  = 32'h0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_pc", fetch_pc, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_wrap_pc", w_fetch_pc, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        // Streaming with decode always ready
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 32'h0);
        check("stream_count", fetch_count, 32'd11);

        // Stall: queue fills to 4 and fetch_pc parks at 16
        step(1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        check("stall_pc", fetch_pc, 32'd16);
        check("stall_head", out_pc, 32'd0);
        // Full with ready held: push and pop every cycle
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect with 3 entries queued, unaligned target
        step(1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h0000_0103);
        check("redir_valid", 32'(out_valid), 32'h0);
        check("redir_pc", fetch_pc, 32'h100);
        step(1'b1, 1'b0, 32'h0);
        check("redir_head", out_pc, 32'h100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: last wins
        step(1'b1, 1'b1, 32'h200);
        step(1'b1, 1'b1, 32'h300);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Halt opcode at address 8
        halt_mode = 1'b1;
        step(1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
`ifdef IF_HALT_EN
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_pc", fetch_pc, 32'd12);
`else
        check("halt_flag", 32'(halted), 32'h0);
`endif
        step(1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        halt_mode = 1'b0;

        // Reset mid-stream with entries queued
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_pc", fetch_pc, 32'h0);
        check("mrst_count", fetch_count, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);

        // Random ready and occasional redirects
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                 32'($urandom_range(0, 32'h0000_0FFF)));
        end
        step(1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
